// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-stage sequencer (master) and the data cache (slave).
interface mem_access_unit_if;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic        dhit;
   logic [31:0] dmemload;

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore,
      input  dhit, dmemload
   );

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore,
      output dhit, dmemload
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store sequencer: registers one bus access, stalls until dhit, returns load data.
// Optional LL/SC link tracking is compiled in with `define MEM_ACCESS_LLSC_EN.
module mem_access_unit (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              ll,
   input  logic              sc,
   input  logic              flush,
   input  logic [31:0]       memAddr,
   input  logic [31:0]       storeData,
   mem_access_unit_if.master dmem,
   output logic [31:0]       dload,
   output logic              memStall,
   output logic              accessDone
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic        ren_q, ren_d, wen_q, wen_d;
   logic [31:0] addr_q, addr_d, store_q, store_d, dload_q, dload_d;
   logic        request;
   logic        unused_bits;

   assign request     = (memRead | memWrite) & ~flush;
   assign unused_bits = ^{ll, sc, memAddr[1:0]};

`ifdef MEM_ACCESS_LLSC_EN
   logic        link_v_q, link_v_d, ll_q, ll_d, sc_q, sc_d;
   logic [29:0] link_a_q, link_a_d;
   logic        sc_ok;

   assign sc_ok = link_v_q && (link_a_q == memAddr[31:2]);
`endif

   always_comb begin
      state_d  = state_q;
      ren_d    = ren_q;
      wen_d    = wen_q;
      addr_d   = addr_q;
      store_d  = store_q;
      dload_d  = dload_q;
`ifdef MEM_ACCESS_LLSC_EN
      link_v_d = link_v_q;
      link_a_d = link_a_q;
      ll_d     = ll_q;
      sc_d     = sc_q;
`endif
      case (state_q)
         IDLE: if (request) begin
            ren_d   = ~memWrite;
            wen_d   = memWrite;
            addr_d  = {memAddr[31:2], 2'b00};
            store_d = storeData;
            state_d = BUSY;
`ifdef MEM_ACCESS_LLSC_EN
            ll_d = ll & ~memWrite;
            sc_d = sc & memWrite;
            // A failing SC never reaches the bus; it retires with status 0.
            if (sc && memWrite && !sc_ok) begin
               ren_d    = 1'b0;
               wen_d    = 1'b0;
               dload_d  = 32'd0;
               link_v_d = 1'b0;
               state_d  = DONE;
            end
`endif
         end
         BUSY: if (dmem.dhit) begin
            ren_d   = 1'b0;
            wen_d   = 1'b0;
            state_d = DONE;
            if (ren_q) dload_d = dmem.dmemload;
`ifdef MEM_ACCESS_LLSC_EN
            if (ren_q && ll_q) begin
               link_v_d = 1'b1;
               link_a_d = addr_q[31:2];
            end
            if (wen_q && sc_q) begin
               dload_d  = 32'd1;
               link_v_d = 1'b0;
            end else if (wen_q && (link_a_q == addr_q[31:2])) begin
               link_v_d = 1'b0;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q  <= IDLE;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         addr_q   <= 32'd0;
         store_q  <= 32'd0;
         dload_q  <= 32'd0;
`ifdef MEM_ACCESS_LLSC_EN
         link_v_q <= 1'b0;
         link_a_q <= 30'd0;
         ll_q     <= 1'b0;
         sc_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ren_q    <= ren_d;
         wen_q    <= wen_d;
         addr_q   <= addr_d;
         store_q  <= store_d;
         dload_q  <= dload_d;
`ifdef MEM_ACCESS_LLSC_EN
         link_v_q <= link_v_d;
         link_a_q <= link_a_d;
         ll_q     <= ll_d;
         sc_q     <= sc_d;
`endif
      end
   end

   assign dmem.dmemREN   = ren_q;
   assign dmem.dmemWEN   = wen_q;
   assign dmem.dmemaddr  = addr_q;
   assign dmem.dmemstore = store_q;
   assign dload          = dload_q;
   assign accessDone     = (state_q == DONE);
   assign memStall       = ((state_q == IDLE) && request) || (state_q == BUSY);

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a transaction-level timeline model predicts every output each cycle.
module tb_mem_access_unit;
   logic        CLK = 1'b0;
   logic        nRST;
   logic        memRead, memWrite, ll, sc, flush;
   logic [31:0] memAddr, storeData;
   logic [31:0] dload;
   logic        memStall, accessDone;

   mem_access_unit_if dmem_if ();

   mem_access_unit dut (
      .CLK(CLK), .nRST(nRST), .memRead(memRead), .memWrite(memWrite),
      .ll(ll), .sc(sc), .flush(flush), .memAddr(memAddr), .storeData(storeData),
      .dmem(dmem_if.master), .dload(dload), .memStall(memStall), .accessDone(accessDone)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   // model state and per-cycle expectations
   logic [31:0] m_dload;
   bit          m_lv;
   logic [29:0] m_la;
   bit          chk_en = 0;
   bit          e_ren, e_wen, e_stall, e_done, e_bus;
   logic [31:0] e_addr, e_store, e_dload;

   int ren_cnt = 0, wen_cnt = 0, stall_cnt = 0, done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      ren_cnt   += int'(dmem_if.dmemREN);
      wen_cnt   += int'(dmem_if.dmemWEN);
      stall_cnt += int'(memStall);
      done_cnt  += int'(accessDone);
      if (chk_en) begin
         chk("dmemREN", 32'(dmem_if.dmemREN), 32'(e_ren));
         chk("dmemWEN", 32'(dmem_if.dmemWEN), 32'(e_wen));
         chk("memStall", 32'(memStall), 32'(e_stall));
         chk("accessDone", 32'(accessDone), 32'(e_done));
         chk("dload", dload, e_dload);
         if (e_bus) begin
            chk("dmemaddr", dmem_if.dmemaddr, e_addr);
            chk("dmemstore", dmem_if.dmemstore, e_store);
         end
      end
   end

   task automatic drv(input bit rd, wr, l, s, fl, input logic [31:0] a, d,
                      input bit dh, input logic [31:0] dl);
      @(posedge CLK); #1;
      memRead = rd; memWrite = wr; ll = l; sc = s; flush = fl;
      memAddr = a; storeData = d; dmem_if.dhit = dh; dmem_if.dmemload = dl;
   endtask

   task automatic ex(input bit ren, wen, stall, done, bus);
      e_ren = ren; e_wen = wen; e_stall = stall; e_done = done; e_bus = bus;
      e_dload = m_dload;
   endtask

   task automatic idle_cycle();
      drv(0, 0, 0, 0, 0, 32'd0, 32'd0, 1'($urandom_range(0, 1)), $urandom);
      ex(0, 0, 0, 0, 0);
   endtask

   // One access: request cycle, n BUSY cycles (dhit on the last), DONE, then one idle cycle.
   task automatic access(input bit rd, wr, l, s, input logic [31:0] a, d,
                         input int n_in, input logic [31:0] rdata, input bit fl_busy);
      bit is_rd, is_wr, fail;
      int n;
      is_wr = wr;
      is_rd = rd & ~wr;
      n     = n_in;
      fail  = 0;
`ifdef MEM_ACCESS_LLSC_EN
      fail = is_wr && s && !(m_lv && m_la == a[31:2]);
      if (fail) n = 0;
`endif
      drv(rd, wr, l, s, 0, a, d, 1'($urandom_range(0, 1)), $urandom);
      ex(0, 0, 1, 0, 0);
      for (int k = 1; k <= n; k++) begin
         drv(rd, wr, l, s, fl_busy ? 1'($urandom_range(0, 1)) : 1'b0, a, d,
             k == n, (k == n) ? rdata : $urandom);
         e_addr = {a[31:2], 2'b00};
         e_store = d;
         ex(is_rd, is_wr, 1, 0, 1);
      end
      drv(rd, wr, l, s, 0, a, d, 1'($urandom_range(0, 1)), $urandom);
      if (is_rd) m_dload = rdata;
`ifdef MEM_ACCESS_LLSC_EN
      if (is_rd && l) begin m_lv = 1; m_la = a[31:2]; end
      if (is_wr && s) begin
         m_dload = fail ? 32'd0 : 32'd1;
         m_lv = 0;
      end else if (is_wr && m_lv && m_la == a[31:2]) begin
         m_lv = 0;
      end
`endif
      ex(0, 0, 0, 1, 0);
      idle_cycle();
   endtask

   task automatic flush_idle();
      drv(1, 1'($urandom_range(0, 1)), 0, 0, 1, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
      ex(0, 0, 0, 0, 0);
      idle_cycle();
   endtask

   initial begin
      int r0, w0, s0, d0;
      nRST = 0; memRead = 0; memWrite = 0; ll = 0; sc = 0; flush = 0;
      memAddr = 0; storeData = 0; dmem_if.dhit = 0; dmem_if.dmemload = 0;
      m_dload = 0; m_lv = 0; m_la = 0;
      repeat (2) @(posedge CLK);
      #1 nRST = 1;
      ex(0, 0, 0, 0, 0);
      chk_en = 1;
      chk("reset_dmemaddr", dmem_if.dmemaddr, 32'd0);
      chk("reset_dmemstore", dmem_if.dmemstore, 32'd0);
      chk("reset_dload", dload, 32'd0);
      idle_cycle();

      // load 0x1006, dhit on 3rd BUSY cycle
      r0 = ren_cnt; s0 = stall_cnt; d0 = done_cnt;
      access(1, 0, 0, 0, 32'h0000_1006, 32'h0, 3, 32'hDEAD_BEEF, 0);
      chk("load_addr_lit", dmem_if.dmemaddr, 32'h0000_1004);
      chk("load_dload_lit", dload, 32'hDEAD_BEEF);
      chk("load_ren_cycles", 32'(ren_cnt - r0), 32'd3);
      chk("load_stall_cycles", 32'(stall_cnt - s0), 32'd4);
      chk("load_done_pulses", 32'(done_cnt - d0), 32'd1);

      // store 0x12345678 to 0x40, immediate dhit
      r0 = ren_cnt; w0 = wen_cnt;
      access(0, 1, 0, 0, 32'h40, 32'h1234_5678, 1, 32'h0, 0);
      chk("store_data_lit", dmem_if.dmemstore, 32'h1234_5678);
      chk("store_wen_cycles", 32'(wen_cnt - w0), 32'd1);
      chk("store_ren_cycles", 32'(ren_cnt - r0), 32'd0);
      chk("store_dload_kept", dload, 32'hDEAD_BEEF);

      // read and write together: write wins
      r0 = ren_cnt; w0 = wen_cnt;
      access(1, 1, 0, 0, 32'h44, 32'hA5A5_0001, 2, 32'h0, 0);
      chk("both_ren_cycles", 32'(ren_cnt - r0), 32'd0);
      chk("both_wen_cycles", 32'(wen_cnt - w0), 32'd2);

      // flush in IDLE
      r0 = ren_cnt; s0 = stall_cnt;
      flush_idle();
      chk("flush_idle_ren", 32'(ren_cnt - r0), 32'd0);
      chk("flush_idle_stall", 32'(stall_cnt - s0), 32'd0);

      // flush during BUSY
      d0 = done_cnt;
      access(1, 0, 0, 0, 32'h100, 32'h0, 4, 32'h0BAD_F00D, 1);
      chk("flush_busy_done", 32'(done_cnt - d0), 32'd1);

      // reset mid-access
      d0 = done_cnt;
      drv(1, 0, 0, 0, 0, 32'h200, 32'h0, 0, $urandom);
      ex(0, 0, 1, 0, 0);
      drv(1, 0, 0, 0, 0, 32'h200, 32'h0, 0, $urandom);
      e_addr = 32'h200; e_store = 32'h0;
      ex(1, 0, 1, 0, 1);
      nRST = 0;
      drv(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, $urandom);
      nRST = 1;
      m_dload = 0; m_lv = 0;
      ex(0, 0, 0, 0, 0);
      drv(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, $urandom);
      ex(0, 0, 0, 0, 0);
      idle_cycle();
      chk("reset_busy_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef MEM_ACCESS_LLSC_EN
      access(1, 0, 1, 0, 32'h80, 32'h0, 1, 32'h7777_0000, 0);
      w0 = wen_cnt;
      access(0, 1, 0, 1, 32'h80, 32'h5555_AAAA, 2, 32'h0, 0);
      chk("sc_ok_dload", dload, 32'd1);
      chk("sc_ok_wen", 32'(wen_cnt - w0), 32'd2);

      access(1, 0, 1, 0, 32'h80, 32'h0, 1, 32'h1111_2222, 0);
      access(0, 1, 0, 0, 32'h80, 32'h3333_4444, 1, 32'h0, 0);
      w0 = wen_cnt; s0 = stall_cnt;
      access(0, 1, 0, 1, 32'h80, 32'h6666_0000, 3, 32'h0, 0);
      chk("sc_fail_dload", dload, 32'd0);
      chk("sc_fail_wen", 32'(wen_cnt - w0), 32'd0);
      chk("sc_fail_stall", 32'(stall_cnt - s0), 32'd1);

      access(1, 0, 0, 0, 32'h90, 32'h0, 1, 32'hFFFF_0001, 0);
      access(0, 1, 0, 1, 32'h94, 32'h0, 1, 32'h0, 0);
      chk("sc_nolink_dload", dload, 32'd0);
`endif

      for (int i = 0; i < 200; i++) begin
         int kind;
         logic [31:0] a;
         kind = int'($urandom_range(0, 9));
         a = ($urandom_range(0, 3) == 0) ? $urandom
             : 32'h80 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
         if (kind == 0) flush_idle();
         else if (kind <= 4)
            access(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                   int'($urandom_range(1, 4)), $urandom, 1'($urandom_range(0, 1)));
         else if (kind <= 8)
            access(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                   int'($urandom_range(1, 4)), $urandom, 1'($urandom_range(0, 1)));
         else
            access(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                   int'($urandom_range(1, 4)), $urandom, 0);
      end

      @(posedge CLK); #1;
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
